// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(7,4) transmit path.
// Codeword bits are numbered [7:1]. Parity bits sit at positions 1, 2 and 4.
// Data bits map to positions 3, 5, 6 and 7.
// Also provides the encoder function and the transmit FSM state type.
package hamming_pkg;

    localparam int CW_W   = 7;
    localparam int DATA_W = 4;

    // Parity positions
    localparam int P1_POS = 1;
    localparam int P2_POS = 2;
    localparam int P4_POS = 4;

    // Data nibble bit -> codeword position
    localparam int D1_POS = 3;
    localparam int D2_POS = 5;
    localparam int D3_POS = 6;
    localparam int D4_POS = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } tx_state_e;

    // Each parity bit covers the positions whose index has that bit set.
    function automatic logic [CW_W:1] encode_7_4(input logic [DATA_W:1] nibble);
        logic [CW_W:1] cw;
        cw         = 7'd0;
        cw[D1_POS] = nibble[1];
        cw[D2_POS] = nibble[2];
        cw[D3_POS] = nibble[3];
        cw[D4_POS] = nibble[4];
        cw[P1_POS] = cw[3] ^ cw[5] ^ cw[7];
        cw[P2_POS] = cw[3] ^ cw[6] ^ cw[7];
        cw[P4_POS] = cw[5] ^ cw[6] ^ cw[7];
        return cw;
    endfunction

endpackage

// File: rtl/hamming_7_4_parity.sv
// Combinational Hamming(7,4) encoder with optional single-bit error injection.
// Ports:
//   nibble  - data [4:1]
//   inj_pos - 0: no error; 1..7: invert that codeword position
//   cw      - resulting codeword [7:1]
module hamming_7_4_parity
    import hamming_pkg::*;
(
    input  logic [DATA_W:1] nibble,
    input  logic [2:0]      inj_pos,
    output logic [CW_W:1]   cw
);

    logic [CW_W:1] mask_s;

    // Build a one-hot inversion mask from inj_pos and apply it to the clean codeword.
    always_comb begin
        mask_s = 7'd0;
        for (int i = 1; i <= CW_W; i++) begin
            if (inj_pos == 3'(i)) begin
                mask_s[i] = 1'b1;
            end else begin
                mask_s[i] = 1'b0;
            end
        end
        cw = encode_7_4(nibble) ^ mask_s;
    end

endmodule

// File: rtl/hamming_7_4_serial_encoder.sv
// Hamming(7,4) serial transmitter.
// Accepts nibbles over a valid/ready handshake into a one-entry holding register.
// Each nibble is encoded, optionally with one bit inverted. The codeword is then
// shifted out on tx_bit, position 1 first, and also presented in parallel on cw.
// Ports:
//   clk, rst_n         - clock and synchronous active-low reset
//   en                 - global enable; gates nibble acceptance and frame starts
//   din, inj_pos       - nibble [4:1] and error-injection position
//   din_valid          - input valid
//   din_ready          - input ready
//   tx_bit             - serial codeword bit; idle level when no frame is active
//   tx_sof             - high during the position-1 bit
//   tx_active          - high during all 7 bit cycles
//   cw                 - transmitted codeword [7:1], held until the next frame
//   cw_valid           - one-cycle pulse coincident with tx_sof
//   frame_cnt          - frames started, wrapping
module hamming_7_4_serial_encoder
    import hamming_pkg::*;
#(
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_LEVEL = 1'b0,
    parameter int   CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W:1]   din,
    input  logic [2:0]        inj_pos,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              tx_bit,
    output logic              tx_sof,
    output logic              tx_active,
    output logic [CW_W:1]     cw,
    output logic              cw_valid,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam logic       GAP_EN   = (GAP_CYCLES != 0) ? 1'b1 : 1'b0;
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    tx_state_e         state_r;
    logic              hold_full_r;
    logic [DATA_W:1]   hold_din_r;
    logic [2:0]        hold_inj_r;
    logic [5:0]        shift_r;
    logic [2:0]        bit_cnt_r;
    logic [3:0]        gap_cnt_r;
    logic              tx_bit_r;
    logic              tx_sof_r;
    logic              tx_active_r;
    logic [CW_W:1]     cw_r;
    logic              cw_valid_r;
    logic [CNT_W-1:0]  frame_cnt_r;
    logic [CW_W:1]     enc_s;
    logic              din_ready_s;
    logic              load_s;

    hamming_7_4_parity u_parity (
        .nibble  (hold_din_r),
        .inj_pos (hold_inj_r),
        .cw      (enc_s)
    );

    // Ready depends only on registered state and enable.
    // It is forced low while reset is asserted.
    assign din_ready_s = en & ~hold_full_r & rst_n;

    // Decide whether a new frame starts at this edge.
    // A frame can start from IDLE, directly after pos7 when there is no gap,
    // or at the end of the gap.
    always_comb begin
        load_s = 1'b0;
        case (state_r)
            IDLE: begin
                load_s = hold_full_r & en;
            end
            SHIFT: begin
                if ((bit_cnt_r == 3'd6) && !GAP_EN) begin
                    load_s = hold_full_r & en;
                end else begin
                    load_s = 1'b0;
                end
            end
            GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    load_s = hold_full_r & en;
                end else begin
                    load_s = 1'b0;
                end
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Holding register, transmit FSM, shifter, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            hold_full_r <= 1'b0;
            hold_din_r  <= 4'd0;
            hold_inj_r  <= 3'd0;
            shift_r     <= 6'd0;
            bit_cnt_r   <= 3'd0;
            gap_cnt_r   <= 4'd0;
            tx_bit_r    <= IDLE_LEVEL;
            tx_sof_r    <= 1'b0;
            tx_active_r <= 1'b0;
            cw_r        <= 7'd0;
            cw_valid_r  <= 1'b0;
            frame_cnt_r <= '0;
        end else begin
            tx_sof_r   <= 1'b0;
            cw_valid_r <= 1'b0;
            if (load_s) begin
                // Load requires hold_full_r, and a handshake requires it clear,
                // so the two never happen at the same edge.
                state_r     <= SHIFT;
                hold_full_r <= 1'b0;
                cw_r        <= enc_s;
                tx_bit_r    <= enc_s[1];
                shift_r     <= enc_s[7:2];
                bit_cnt_r   <= 3'd0;
                tx_active_r <= 1'b1;
                tx_sof_r    <= 1'b1;
                cw_valid_r  <= 1'b1;
                frame_cnt_r <= frame_cnt_r + CNT_W'(1);
            end else begin
                if (din_valid && din_ready_s) begin
                    hold_full_r <= 1'b1;
                    hold_din_r  <= din;
                    hold_inj_r  <= inj_pos;
                end else begin
                    hold_full_r <= hold_full_r;
                end
                case (state_r)
                    SHIFT: begin
                        if (bit_cnt_r != 3'd6) begin
                            tx_bit_r  <= shift_r[0];
                            shift_r   <= {1'b0, shift_r[5:1]};
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end else if (GAP_EN) begin
                            state_r     <= GAP;
                            gap_cnt_r   <= 4'd0;
                            tx_bit_r    <= IDLE_LEVEL;
                            tx_active_r <= 1'b0;
                        end else begin
                            state_r     <= IDLE;
                            tx_bit_r    <= IDLE_LEVEL;
                            tx_active_r <= 1'b0;
                        end
                    end
                    GAP: begin
                        if (gap_cnt_r == GAP_LAST) begin
                            state_r <= IDLE;
                        end else begin
                            gap_cnt_r <= gap_cnt_r + 4'd1;
                        end
                    end
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    default: begin
                        state_r     <= IDLE;
                        tx_bit_r    <= IDLE_LEVEL;
                        tx_active_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign din_ready = din_ready_s;
    assign tx_bit    = tx_bit_r;
    assign tx_sof    = tx_sof_r;
    assign tx_active = tx_active_r;
    assign cw        = cw_r;
    assign cw_valid  = cw_valid_r;
    assign frame_cnt = frame_cnt_r;

endmodule
